// File: rtl/ems_page_mapper.sv
// EMS page-frame register file and window decoder feeding the SDRAM RAM block.
// Optional I/O readback of the registers is built when EMS_READBACK_EN is defined.
module ems_page_mapper #(
    parameter logic [9:0] EMS_IO_BASE    = 10'h260,
    parameter logic [1:0] DEFAULT_FRAME  = 2'd1,
    parameter logic       DEFAULT_ENABLE = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [19:0]      address,
    input  logic [7:0]       internal_data_bus,
    input  logic             io_write_n,
    input  logic             io_read_n,
    output logic [7:0]       data_bus_out,
    output logic             ems_io_select_n,
    output logic [0:3][6:0]  map_ems,
    output logic             ems_b1,
    output logic             ems_b2,
    output logic             ems_b3,
    output logic             ems_b4
);

    typedef enum logic [0:0] {
        W_IDLE  = 1'b0,
        W_ARMED = 1'b1
    } wstate_t;

    wstate_t          state_q, state_d;
    logic             wr_prev_q;
    logic [9:0]       waddr_q, waddr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             commit_s;
    logic [9:0]       woff_s;

    logic [0:3][6:0]  page_q, page_d;
    logic [0:3]       pen_q, pen_d;
    logic             ctl_en_q, ctl_en_d;
    logic [1:0]       ctl_frame_q, ctl_frame_d;

    logic [3:0]       frame_base_s;
    logic             hit_s;
    logic [1:0]       win_s;
    logic             unused_s;

    // Write-strobe state, capture registers and previous strobe level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= W_IDLE;
            wr_prev_q <= 1'b0;
            waddr_q   <= 10'd0;
            wdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_prev_q <= io_write_n;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Arm only on a genuine falling edge; wr_prev_q resets low so a strobe
    // already held low across reset release is ignored.
    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        commit_s = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (!io_write_n && wr_prev_q) begin
                    state_d = W_ARMED;
                    waddr_d = address[9:0];
                    wdata_d = internal_data_bus;
                end else begin
                    state_d = W_IDLE;
                end
            end
            W_ARMED: begin
                if (!io_write_n) begin
                    wdata_d = internal_data_bus;
                end else begin
                    state_d  = W_IDLE;
                    commit_s = 1'b1;
                end
            end
            default: begin
                state_d = W_IDLE;
            end
        endcase
    end

    assign woff_s = waddr_q - EMS_IO_BASE;

    // Register-file update on commit
    always_comb begin
        page_d      = page_q;
        pen_d       = pen_q;
        ctl_en_d    = ctl_en_q;
        ctl_frame_d = ctl_frame_q;
        if (commit_s) begin
            if (woff_s < 10'd4) begin
                page_d[woff_s[1:0]] = wdata_q[6:0];
                pen_d[woff_s[1:0]]  = wdata_q[7];
            end else if (woff_s == 10'd4) begin
                ctl_en_d    = wdata_q[0];
                ctl_frame_d = wdata_q[2:1];
            end else begin
                page_d = page_q;
            end
        end else begin
            page_d = page_q;
        end
    end

    // Register file storage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            page_q      <= '0;
            pen_q       <= 4'b0000;
            ctl_en_q    <= DEFAULT_ENABLE;
            ctl_frame_q <= DEFAULT_FRAME;
        end else begin
            page_q      <= page_d;
            pen_q       <= pen_d;
            ctl_en_q    <= ctl_en_d;
            ctl_frame_q <= ctl_frame_d;
        end
    end

    // Strobes stay combinational: the RAM block uses them against the same-cycle address.
    assign frame_base_s = 4'hC + {2'b00, ctl_frame_q};
    assign hit_s        = ctl_en_q && (ctl_frame_q != 2'd3) && (address[19:16] == frame_base_s);
    assign win_s        = address[15:14];

    assign ems_b1  = hit_s && (win_s == 2'd0) && pen_q[0];
    assign ems_b2  = hit_s && (win_s == 2'd1) && pen_q[1];
    assign ems_b3  = hit_s && (win_s == 2'd2) && pen_q[2];
    assign ems_b4  = hit_s && (win_s == 2'd3) && pen_q[3];
    assign map_ems = page_q;

`ifdef EMS_READBACK_EN
    logic [9:0] rd_off_s;
    logic       rd_hit_s;
    logic [7:0] rd_data_d, rd_data_q;

    assign rd_off_s        = address[9:0] - EMS_IO_BASE;
    assign rd_hit_s        = !io_read_n && (rd_off_s <= 10'd4);
    assign ems_io_select_n = !rd_hit_s;

    // Readback mux
    always_comb begin
        rd_data_d = 8'd0;
        if (rd_hit_s) begin
            if (rd_off_s == 10'd4) begin
                rd_data_d = {5'b00000, ctl_frame_q, ctl_en_q};
            end else begin
                rd_data_d = {pen_q[rd_off_s[1:0]], page_q[rd_off_s[1:0]]};
            end
        end else begin
            rd_data_d = 8'd0;
        end
    end

    // Registered readback data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= 8'd0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign data_bus_out = rd_data_q;
    assign unused_s     = ^address[13:10];
`else
    assign data_bus_out    = 8'd0;
    assign ems_io_select_n = 1'b1;
    assign unused_s        = ^{address[13:10], io_read_n};
`endif

endmodule

// File: tb/tb_ems_page_mapper.sv
// Self-checking bench for ems_page_mapper: a register-file model predicts
// strobes/pages, expectations go through a scoreboard queue.
module tb_ems_page_mapper;

    logic             clock;
    logic             reset_n;
    logic [19:0]      address;
    logic [7:0]       internal_data_bus;
    logic             io_write_n;
    logic             io_read_n;
    logic [7:0]       data_bus_out;
    logic             ems_io_select_n;
    logic [0:3][6:0]  map_ems;
    logic             ems_b1, ems_b2, ems_b3, ems_b4;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0]  strb;
        logic [27:0] map;
    } exp_t;
    exp_t sb_q[$];

    logic [6:0] m_page [0:3];
    logic       m_pen  [0:3];
    logic       m_en;
    logic [1:0] m_frame;

    ems_page_mapper dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .address           (address),
        .internal_data_bus (internal_data_bus),
        .io_write_n        (io_write_n),
        .io_read_n         (io_read_n),
        .data_bus_out      (data_bus_out),
        .ems_io_select_n   (ems_io_select_n),
        .map_ems           (map_ems),
        .ems_b1            (ems_b1),
        .ems_b2            (ems_b2),
        .ems_b3            (ems_b3),
        .ems_b4            (ems_b4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_page[i] = 7'd0;
            m_pen[i]  = 1'b0;
        end
        m_en    = 1'b0;
        m_frame = 2'd1;
    endtask

    task automatic model_commit(input logic [9:0] port, input logic [7:0] d);
        case (port)
            10'h260, 10'h261, 10'h262, 10'h263: begin
                m_page[port - 10'h260] = d[6:0];
                m_pen[port - 10'h260]  = d[7];
            end
            10'h264: begin
                m_en    = d[0];
                m_frame = d[2:1];
            end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] exp_strb(input logic [19:0] a);
        logic [3:0] nib;
        logic [3:0] r;
        r = 4'b0000;
        case (m_frame)
            2'd0: nib = 4'hC;
            2'd1: nib = 4'hD;
            2'd2: nib = 4'hE;
            default: nib = 4'h0;
        endcase
        if (m_en && m_frame != 2'd3 && a[19:16] == nib)
            r[a[15:14]] = m_pen[a[15:14]];
        return r;
    endfunction

    task automatic sb_push();
        exp_t e;
        e.strb = exp_strb(address);
        e.map  = {m_page[0], m_page[1], m_page[2], m_page[3]};
        sb_q.push_back(e);
    endtask

    task automatic io_wr(input logic [9:0] port, input logic [7:0] d);
        @(negedge clock);
        address = {10'h000, port};
        internal_data_bus = d;
        io_write_n = 1'b0;
        @(negedge clock);
        io_write_n = 1'b1;
        @(negedge clock);
        model_commit(port, d);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        io_write_n = 1'b1;
        io_read_n = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        address = 20'hD4000;
        sb_push();
        #1;
        e = sb_q.pop_front();
        compared++;
        if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e) begin
            mismatched++;
            $display("FAIL reset_map addr=%05h got strb=%b map=%07h exp strb=%b map=%07h",
                     address, {ems_b4, ems_b3, ems_b2, ems_b1}, map_ems, e.strb, e.map);
        end
        compared++;
        if (data_bus_out !== 8'h00 || ems_io_select_n !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_io got data=%02h sel=%b exp data=00 sel=1", data_bus_out, ems_io_select_n);
        end
    endtask

    task automatic test_readback(input logic [9:0] port);
        logic [7:0] exp_d;
        logic       exp_sel;
        int         off;
        off = int'(port) - 32'h260;
        exp_d = 8'h00;
        exp_sel = 1'b1;
`ifdef EMS_READBACK_EN
        if (off >= 0 && off <= 3) begin
            exp_d = {m_pen[off], m_page[off]};
            exp_sel = 1'b0;
        end else if (off == 4) begin
            exp_d = {5'b00000, m_frame, m_en};
            exp_sel = 1'b0;
        end
`endif
        @(negedge clock);
        address = {10'h000, port};
        io_read_n = 1'b0;
        #1;
        compared++;
        if (ems_io_select_n !== exp_sel) begin
            mismatched++;
            $display("FAIL rd_select port=%03h got=%b exp=%b", port, ems_io_select_n, exp_sel);
        end
        repeat (2) @(negedge clock);
        compared++;
        if (data_bus_out !== exp_d) begin
            mismatched++;
            $display("FAIL rd_data port=%03h got=%02h exp=%02h", port, data_bus_out, exp_d);
        end
        io_read_n = 1'b1;
        @(negedge clock);
        compared++;
        if (data_bus_out !== 8'h00 || ems_io_select_n !== 1'b1) begin
            mismatched++;
            $display("FAIL rd_release got data=%02h sel=%b exp data=00 sel=1", data_bus_out, ems_io_select_n);
        end
    endtask

    task automatic test_map_basic();
        logic [19:0] addrs [4] = '{20'hD4123, 20'hD0000, 20'hDC000, 20'hC4123};
        exp_t e;
        io_wr(10'h264, 8'h03);
        io_wr(10'h261, 8'h85);
        for (int i = 0; i < 4; i++) begin
            address = addrs[i];
            sb_push();
            #1;
            e = sb_q.pop_front();
            compared++;
            if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e) begin
                mismatched++;
                $display("FAIL map_basic addr=%05h got strb=%b map=%07h exp strb=%b map=%07h",
                         address, {ems_b4, ems_b3, ems_b2, ems_b1}, map_ems, e.strb, e.map);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_long_strobe();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            address = 20'h00262;
            internal_data_bus = (i == 9) ? 8'h9F : 8'h81;
            io_write_n = (i == 10) ? 1'b1 : 1'b0;
            sb_push();
            #1;
            e = sb_q.pop_front();
            compared++;
            if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e) begin
                mismatched++;
                $display("FAIL long_strobe_early cyc=%0d got map=%07h exp map=%07h", i, map_ems, e.map);
            end
        end
        @(negedge clock);
        model_commit(10'h262, 8'h9F);
        internal_data_bus = 8'h00;
        for (int i = 0; i < 3; i++) begin
            address = 20'hD8000;
            sb_push();
            #1;
            e = sb_q.pop_front();
            compared++;
            if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e) begin
                mismatched++;
                $display("FAIL long_strobe_commit cyc=%0d got strb=%b map=%07h exp strb=%b map=%07h",
                         i, {ems_b4, ems_b3, ems_b2, ems_b1}, map_ems, e.strb, e.map);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_frame_ctl();
        logic [19:0] addrs [3] = '{20'hEC000, 20'hE4000, 20'hD4000};
        exp_t e;
        io_wr(10'h264, 8'h07);
        for (int a = 32'hC0000; a <= 32'hEC000; a += 32'h4000) begin
            address = a[19:0];
            sb_push();
            #1;
            e = sb_q.pop_front();
            compared++;
            if ({ems_b4, ems_b3, ems_b2, ems_b1} !== e.strb || e.strb !== 4'b0000) begin
                mismatched++;
                $display("FAIL frame3 addr=%05h got strb=%b exp=%b", address, {ems_b4, ems_b3, ems_b2, ems_b1}, e.strb);
            end
        end
        io_wr(10'h264, 8'h05);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) io_wr(10'h263, 8'h8A);
            for (int i = 0; i < 3; i++) begin
                address = addrs[i];
                sb_push();
                #1;
                e = sb_q.pop_front();
                compared++;
                if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e) begin
                    mismatched++;
                    $display("FAIL frame_e pass=%0d addr=%05h got strb=%b map=%07h exp strb=%b map=%07h",
                             pass, address, {ems_b4, ems_b3, ems_b2, ems_b1}, map_ems, e.strb, e.map);
                end
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        exp_t e;
        @(negedge clock);
        address = 20'h00260;
        internal_data_bus = 8'hC5;
        io_write_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        io_write_n = 1'b1;
        repeat (3) @(negedge clock);
        io_wr(10'h264, 8'h03);
        address = 20'hD0000;
        sb_push();
        #1;
        e = sb_q.pop_front();
        compared++;
        if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e || map_ems[0] !== 7'h00) begin
            mismatched++;
            $display("FAIL reset_mid_strobe got strb=%b map=%07h exp strb=%b map=%07h",
                     {ems_b4, ems_b3, ems_b2, ems_b1}, map_ems, e.strb, e.map);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals  [4] = '{8'h81, 8'h92, 8'h23, 8'hB4};
        logic [19:0] addrs [4] = '{20'hD0010, 20'hD4020, 20'hD8030, 20'hDC040};
        exp_t e;
        for (int i = 0; i < 4; i++) io_wr(10'h260 + 10'(i), vals[i]);
        for (int i = 0; i < 4; i++) begin
            address = addrs[i];
            sb_push();
            #1;
            e = sb_q.pop_front();
            compared++;
            if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e) begin
                mismatched++;
                $display("FAIL back_to_back addr=%05h got strb=%b map=%07h exp strb=%b map=%07h",
                         address, {ems_b4, ems_b3, ems_b2, ems_b1}, map_ems, e.strb, e.map);
            end
        end
    endtask

    task automatic test_bad_ports();
        exp_t e;
        for (int p = 32'h265; p <= 32'h267; p++) io_wr(p[9:0], 8'hFF);
        for (int i = 0; i < 4; i++) begin
            address = 20'hD0000 + 20'(i * 32'h4000);
            sb_push();
            #1;
            e = sb_q.pop_front();
            compared++;
            if ({ems_b4, ems_b3, ems_b2, ems_b1, map_ems} !== e) begin
                mismatched++;
                $display("FAIL bad_ports addr=%05h got strb=%b map=%07h exp strb=%b map=%07h",
                         address, {ems_b4, ems_b3, ems_b2, ems_b1}, map_ems, e.strb, e.map);
            end
        end
        test_readback(10'h265);
    endtask

    initial begin
        reset_n = 1'b0;
        address = 20'h00000;
        internal_data_bus = 8'h00;
        io_write_n = 1'b1;
        io_read_n = 1'b1;
        model_reset();
        test_reset();
        test_readback(10'h264);
        test_map_basic();
        test_readback(10'h261);
        test_long_strobe();
        test_frame_ctl();
        test_readback(10'h264);
        test_reset_mid_strobe();
        test_back_to_back();
        test_readback(10'h262);
        test_bad_ports();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
